button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//   Conditions one raw push-button input for the LED counter and other user-facing logic.
//   Synchronises the asynchronous pin and rejects contact bounce.
//   Produces a clean level plus single-cycle press, release and long-press pulses.
//   Sits directly upstream of the LED counter. One instance per board button.
// PARAMETERS
//   DEBOUNCE_CYCLES    270000    consecutive stable synchronised samples needed to accept a change (>=1)
//   LONG_PRESS_CYCLES  13500000  cycles after press_pulse before long_press_pulse fires (>=1)
//   ACTIVE_LOW         1         1: pin reads 0 when pressed; 0: pin reads 1 when pressed
// PORTS
//   clk               in   1  system clock
//   reset             in   1  asynchronous, active-high reset
//   btn_in            in   1  raw button pin, asynchronous to clk, may bounce
//   btn_level         out  1  debounced state, 1 = pressed
//   press_pulse       out  1  1-cycle strobe on an accepted press
//   release_pulse     out  1  1-cycle strobe on an accepted release
//   long_press_pulse  out  1  1-cycle strobe, at most once per press
// BEHAVIOUR
//   Reset (asynchronous, active-high)
//   - All outputs reset to 0. FSM resets to IDLE. Counters reset to 0.
//   - Both synchroniser flops reset to the released pin level (ACTIVE_LOW ? 1 : 0).
//   Synchroniser and sampling
//   - btn_in passes through a 2-flop synchroniser.
//   - pressed_s = sync2 XOR ACTIVE_LOW. The FSM sees only pressed_s.
//   Debounce counter
//   - Width $clog2(DEBOUNCE_CYCLES+1).
//   - Cleared on every FSM state change and whenever the sample disagrees with the pending direction.
//   FSM states
//   - IDLE: btn_level=0. pressed_s=1 -> PRESS_WAIT, and this sample counts as sample 1.
//   - PRESS_WAIT: pressed_s=0 -> IDLE, no pulse. DEBOUNCE_CYCLES consecutive pressed samples
//     -> HELD; press_pulse=1 and btn_level=1 from the next edge.
//   - HELD: hold counter increments each cycle and saturates.
//     When it reaches LONG_PRESS_CYCLES, long_press_pulse=1 for one cycle and long_done is set.
//     pressed_s=0 -> RELEASE_WAIT; this sample counts as sample 1.
//   - RELEASE_WAIT: btn_level stays 1 and the hold counter freezes.
//     pressed_s=1 -> HELD; the glitch is ignored and the hold count resumes.
//     DEBOUNCE_CYCLES consecutive released samples -> IDLE; release_pulse=1 and btn_level=0 from the
//     next edge. Hold counter and long_done are cleared.
//   Timing and widths
//   - Latency from a clean btn_in edge to press_pulse or release_pulse is DEBOUNCE_CYCLES+2 clock edges.
//   - DEBOUNCE_CYCLES=1 means no bounce filtering; latency is 3 edges.
//   - long_press_pulse is asserted LONG_PRESS_CYCLES edges after press_pulse.
//   - Hold counter width is $clog2(LONG_PRESS_CYCLES+1). It never wraps: no second long pulse per press.
//   Pulse rules
//   - All pulses are registered and last exactly 1 cycle.
//   - press_pulse and release_pulse are mutually exclusive.
//   - A release accepted before LONG_PRESS_CYCLES produces no long_press_pulse.
//   Reset mid-operation
//   - Asynchronous return to IDLE with all outputs 0.
//   - A button still held after reset deasserts requires a full new debounce before press_pulse.
// TESTING (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1)
//   1. Reset, btn_in=1 for 20 cycles -> all outputs 0 throughout, no pulses.
//   2. Bounce: btn_in=0 for 3 cycles then 1 for 1 cycle, repeated 5 times, then btn_in=1
//      -> no press_pulse, btn_level stays 0.
//   3. Clean press: btn_in 1->0 and held -> press_pulse high for exactly 1 cycle, 6 edges after the
//      change; btn_level=1 from the same edge.
//   4. Long press: keep btn_in=0 -> long_press_pulse 1 cycle, 10 edges after press_pulse.
//      Hold 50 more cycles -> no further pulses.
//   5. Release glitch in HELD: btn_in=1 for 2 cycles, then 0 -> no release_pulse, btn_level stays 1.
//      Then btn_in=1 held -> release_pulse 6 edges later, btn_level=0.
//   6. Reset mid-press: assert reset 2 cycles after press_pulse -> outputs 0 immediately.
//      Deassert with btn_in=0 -> press_pulse again 6 edges after deassert (sync reload plus full debounce).

Source files
------------

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Synchronises one raw push-button pin, rejects contact bounce
//               and produces a clean pressed level plus single-cycle press,
//               release and long-press strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 13500000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    // Pin level while the button is not pressed; the synchroniser resets to it
    // so that reset release never looks like an edge.
    localparam logic C_PIN_RELEASED = ACTIVE_LOW;

    // The debounce counter holds the number of agreeing samples already seen,
    // so the sample that arrives while it equals DEBOUNCE_CYCLES-1 is the last
    // one needed. With DEBOUNCE_CYCLES=1 this is zero, giving acceptance on
    // the very first sample.
    localparam logic [DB_W-1:0]   C_DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   C_DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]   C_DB_ZERO  = '0;
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_long_done;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    state_t            w_state_nxt;
    logic [DB_W-1:0]   w_db_cnt_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_long_done_nxt;
    logic              w_level_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;

    logic              w_pressed;
    logic              w_db_last;
    logic [DB_W-1:0]   w_db_cnt_inc;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              w_hold_sat;
    logic              w_hold_hit;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= C_PIN_RELEASED;
            r_sync2 <= C_PIN_RELEASED;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Polarity-normalised sample and counter helper terms
    always_comb begin
        w_pressed    = r_sync2 ^ ACTIVE_LOW;
        w_db_last    = (r_db_cnt == C_DB_LAST);
        w_db_cnt_inc = r_db_cnt + C_DB_ONE;
        w_hold_inc   = r_hold + C_HOLD_ONE;
        w_hold_sat   = (r_hold == C_HOLD_MAX);
        w_hold_hit   = (w_hold_inc == C_HOLD_MAX);
    end

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_nxt     = r_state;
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_nxt      = r_hold;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = r_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_level_nxt = 1'b0;
                if (w_pressed) begin
                    if (w_db_last) begin
                        // No filtering configured: accept on the first sample
                        w_state_nxt  = S_HELD;
                        w_press_nxt  = 1'b1;
                        w_level_nxt  = 1'b1;
                        w_db_cnt_nxt = C_DB_ZERO;
                    end else begin
                        // This sample is the first of the run
                        w_state_nxt  = S_PRESS_WAIT;
                        w_db_cnt_nxt = C_DB_ONE;
                    end
                end
            end

            S_PRESS_WAIT: begin
                w_level_nxt = 1'b0;
                if (!w_pressed) begin
                    // Bounce: drop the pending press silently
                    w_state_nxt  = S_IDLE;
                    w_db_cnt_nxt = C_DB_ZERO;
                end else if (w_db_last) begin
                    w_state_nxt  = S_HELD;
                    w_press_nxt  = 1'b1;
                    w_level_nxt  = 1'b1;
                    w_db_cnt_nxt = C_DB_ZERO;
                end else begin
                    w_db_cnt_nxt = w_db_cnt_inc;
                end
            end

            S_HELD: begin
                w_level_nxt = 1'b1;
                if (!w_pressed && w_db_last) begin
                    // Unfiltered release: leave at once, hold tracking resets
                    w_state_nxt     = S_IDLE;
                    w_release_nxt   = 1'b1;
                    w_level_nxt     = 1'b0;
                    w_db_cnt_nxt    = C_DB_ZERO;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    // Hold time keeps counting on the cycle a release starts
                    if (!w_hold_sat) begin
                        w_hold_nxt = w_hold_inc;
                        if (w_hold_hit && !r_long_done) begin
                            w_long_nxt      = 1'b1;
                            w_long_done_nxt = 1'b1;
                        end
                    end
                    if (!w_pressed) begin
                        w_state_nxt  = S_RELEASE_WAIT;
                        w_db_cnt_nxt = C_DB_ONE;
                    end
                end
            end

            S_RELEASE_WAIT: begin
                w_level_nxt = 1'b1;
                if (w_pressed) begin
                    // Glitch while held: resume holding, hold count intact
                    w_state_nxt  = S_HELD;
                    w_db_cnt_nxt = C_DB_ZERO;
                end else if (w_db_last) begin
                    w_state_nxt     = S_IDLE;
                    w_release_nxt   = 1'b1;
                    w_level_nxt     = 1'b0;
                    w_db_cnt_nxt    = C_DB_ZERO;
                    w_hold_nxt      = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = w_db_cnt_inc;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_db_cnt_nxt    = C_DB_ZERO;
                w_hold_nxt      = '0;
                w_long_done_nxt = 1'b0;
                w_level_nxt     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_long_done <= w_long_done_nxt;
            r_level     <= w_level_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
            r_long      <= w_long_nxt;
        end
    end

    assign btn_level        = r_level;
    assign press_pulse      = r_press;
    assign release_pulse    = r_release;
    assign long_press_pulse = r_long;

endmodule
`default_nettype wire
